display_scan_mux: RTL and testbench

//  Time-multiplexed N-digit display scanner; successor to the fixed 8:1 4-bit digit mux.

---
 rtl/display_scan_mux.sv | 128 ++++++++++++
 tb/tb_display_scan_mux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//
// Time-multiplexed N-digit display scanner. A packed digit word is captured
// into a shadow register on load_i. A digit select walks 0..N_DIGITS-1 at a
// prescaled refresh rate. Each cycle the selected digit nibble, the matching
// active-low anode line and a blank flag are registered out. digit_en_i is
// sampled live, so a digit can be masked without reloading the shadow.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digit k>0 is also blanked when shadow digits N_DIGITS-1..k
//   are all zero. Digit 0 is never suppressed.
//   When undefined, only digit_en_i blanks.
//
// Ports
//   clk_i         in   1                 system clock, rising edge
//   rst_ni        in   1                 asynchronous active-low reset
//   data_in_i     in   N_DIGITS*DIGIT_W  packed digits, digit k at [k*DIGIT_W +: DIGIT_W]
//   digit_en_i    in   N_DIGITS          per-digit enable (0 = blanked), live
//   load_i        in   1                 capture data_in_i into shadow this edge
//   digit_out_o   out  DIGIT_W           selected digit value, 0 when blanked
//   anode_o       out  N_DIGITS          one-hot active-low anode, all 1s when blanked
//   sel_o         out  SEL_W             current scan index
//   blank_o       out  1                 current digit suppressed
//   frame_done_o  out  1                 1-cycle pulse after sel wraps to 0
// -----------------------------------------------------------------------------
module display_scan_mux #(
    parameter int N_DIGITS = 8,
    parameter int DIGIT_W  = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [N_DIGITS*DIGIT_W-1:0]                   data_in_i,
    input  logic [N_DIGITS-1:0]                           digit_en_i,
    input  logic                                          load_i,
    output logic [DIGIT_W-1:0]                            digit_out_o,
    output logic [N_DIGITS-1:0]                           anode_o,
    output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] sel_o,
    output logic                                          blank_o,
    output logic                                          frame_done_o
);

    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);

    logic [PS_W-1:0]              prescaler_q, prescaler_d;
    logic [SEL_W-1:0]             sel_q, sel_d;
    logic [N_DIGITS*DIGIT_W-1:0]  shadow_q, shadow_d;
    logic [DIGIT_W-1:0]           digit_out_q, digit_out_d;
    logic [N_DIGITS-1:0]          anode_q, anode_d;
    logic                         blank_q, blank_d;
    logic                         frame_done_q, frame_done_d;
    logic                         tick;

    // Shadow word unpacked into per-digit nibbles for indexed selection.
    logic [DIGIT_W-1:0]           digit_arr [N_DIGITS];
    // suppress[k] = 1 when digit k is a leading zero that should go dark.
    logic [N_DIGITS-1:0]          suppress;

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digits
        assign digit_arr[gi] = shadow_q[gi*DIGIT_W +: DIGIT_W];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Each digit compares its whole upper slice against zero directly rather
    // than chaining through its neighbour, keeping the logic flat.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_lsd
            assign suppress[gi] = 1'b0;
        end else begin : g_upper
            assign suppress[gi] =
                (shadow_q[N_DIGITS*DIGIT_W-1 : gi*DIGIT_W] == '0);
        end
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        tick         = (prescaler_q == PS_LAST);
        prescaler_d  = tick ? '0 : prescaler_q + 1'b1;
        sel_d        = sel_q;
        if (tick) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
        frame_done_d = tick && (sel_q == SEL_LAST);
        shadow_d     = load_i ? data_in_i : shadow_q;

        // Drive stage looks at the pre-edge sel/shadow, so a load landing on
        // the same edge as a tick is shown from the following cycle on.
        blank_d      = ~digit_en_i[sel_q] | suppress[sel_q];
        digit_out_d  = blank_d ? '0 : digit_arr[sel_q];
        anode_d      = '1;
        if (!blank_d) begin
            anode_d[sel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescaler_q  <= '0;
            sel_q        <= '0;
            shadow_q     <= '0;
            digit_out_q  <= '0;
            anode_q      <= '1;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            digit_out_q  <= digit_out_d;
            anode_q      <= anode_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_out_o  = digit_out_q;
    assign anode_o      = anode_q;
    assign sel_o        = sel_q;
    assign blank_o      = blank_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_display_scan_mux
//
// Two instances share clock and reset:
//   dut  : N_DIGITS=4, DIGIT_W=4, TICK_DIV=3, driven with directed and random
//          loads / enable masks.
//   dut8 : N_DIGITS=8, DIGIT_W=4, TICK_DIV=1, reloading digits 7..0 = 7..0
//          every cycle, so its outputs track the scan index directly.
// A reference process predicts the post-edge outputs of both at every rising
// edge from edge counts and the input history, and queues them; a monitor on
// the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_display_scan_mux;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int TD  = 3;
    localparam int N8  = 8;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  digit_en = 4'hF;
    logic        load = 1'b0;
    logic [3:0]  digit_out;
    logic [3:0]  anode;
    logic [1:0]  sel;
    logic        blank;
    logic        frame_done;

    logic [31:0] data8 = 32'h7654_3210;
    logic [7:0]  en8 = 8'hFF;
    logic        load8 = 1'b1;
    logic [3:0]  digit_out8;
    logic [7:0]  anode8;
    logic [2:0]  sel8;
    logic        blank8;
    logic        frame_done8;

    always #5 clk = ~clk;

    display_scan_mux #(.N_DIGITS(N), .DIGIT_W(W), .TICK_DIV(TD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(data_in), .digit_en_i(digit_en),
        .load_i(load), .digit_out_o(digit_out), .anode_o(anode), .sel_o(sel),
        .blank_o(blank), .frame_done_o(frame_done)
    );

    display_scan_mux #(.N_DIGITS(N8), .DIGIT_W(W), .TICK_DIV(1)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(data8), .digit_en_i(en8),
        .load_i(load8), .digit_out_o(digit_out8), .anode_o(anode8), .sel_o(sel8),
        .blank_o(blank8), .frame_done_o(frame_done8)
    );

    typedef struct {
        logic [3:0] dout;
        logic [3:0] an;
        logic [1:0] sel;
        logic       blank;
        logic       fd;
        logic [3:0] dout8;
        logic [7:0] an8;
        logic [2:0] sel8;
        logic       blank8;
        logic       fd8;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          p = 0;            // rising edges seen since reset released
    logic [15:0] shadow_m = '0;    // digits the display should currently hold

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Digit k is dark if its enable is off, or (zero blanking on) it and every
    // more significant digit are zero, digit 0 excepted.
    function automatic bit model_blank(input logic [15:0] sh, input logic [3:0] en, input int k);
        return !en[k] || (LZ && (k > 0) && ((sh >> (k*W)) == 16'h0));
    endfunction

    // Reference model: predicts outputs right after each rising edge.
    initial begin : model
        exp_t e;
        int   s;
        int   k8;
        bit   bl;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                p        = 0;
                shadow_m = '0;
                e.dout = 4'h0;  e.an = 4'hF;   e.sel = 2'd0;  e.blank = 1'b1;  e.fd = 1'b0;
                e.dout8 = 4'h0; e.an8 = 8'hFF; e.sel8 = 3'd0; e.blank8 = 1'b1; e.fd8 = 1'b0;
            end else begin
                s        = (p / TD) % N;
                k8       = p % N8;
                bl       = model_blank(shadow_m, digit_en, s);
                e.blank  = bl;
                e.dout   = bl ? 4'h0 : 4'(shadow_m >> (W*s));
                e.an     = bl ? 4'hF : ~(4'b0001 << s);
                e.sel    = 2'(((p + 1) / TD) % N);
                e.fd     = ((p + 1) % (TD * N)) == 0;
                e.dout8  = 4'(k8);
                e.an8    = ~(8'b0000_0001 << k8);
                e.sel8   = 3'((p + 1) % N8);
                e.blank8 = 1'b0;
                e.fd8    = ((p + 1) % N8) == 0;
                if (load) shadow_m = data_in;
                p++;
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("digit_out",   32'(digit_out),   32'(e.dout));
                check("anode",       32'(anode),       32'(e.an));
                check("sel",         32'(sel),         32'(e.sel));
                check("blank",       32'(blank),       32'(e.blank));
                check("frame_done",  32'(frame_done),  32'(e.fd));
                check("digit_out8",  32'(digit_out8),  32'(e.dout8));
                check("anode8",      32'(anode8),      32'(e.an8));
                check("sel8",        32'(sel8),        32'(e.sel8));
                check("blank8",      32'(blank8),      32'(e.blank8));
                check("frame_done8", 32'(frame_done8), 32'(e.fd8));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        $display("load data=%h en=%b", v, digit_en);
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Waits (bounded) until the model says the next edge is a tick from
    // sel_from; want_tick=0 just waits for sel==sel_from.
    task automatic wait_state(input string nm, input int sel_from, input bit want_tick);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            hit = ((p / TD) % N == sel_from) && (!want_tick || (p % TD == TD - 1));
            if (!hit) @(negedge clk);
        end
        if (!hit) begin
            errors++;
            checks++;
            $display("FAIL %s: wait bound expired at %0t", nm, $time);
        end
    endtask

    initial begin : stimulus
        cyc(3);
        rst_n = 1'b1;

        // Plain scan of 1234 over a few frames.
        do_load(16'h1234);
        cyc(30);

        // Enable mask: digits 1 and 3 dark.
        digit_en = 4'b0101;
        $display("enable mask en=%b", digit_en);
        cyc(24);
        digit_en = 4'hF;

        // Load landing on the tick edge from digit 1 into digit 2.
        wait_state("collision_wait", 1, 1'b1);
        do_load(16'hABCD);
        cyc(15);

        // Leading-zero patterns.
        do_load(16'h0050);
        cyc(24);
        do_load(16'h0000);
        cyc(24);

        // Randomised loads and enable masks.
        for (int i = 0; i < 300; i++) begin
            data_in = 16'($urandom);
            load    = ($urandom_range(0, 5) == 0);
            if (i % 25 == 0) digit_en = 4'($urandom);
            if (load) $display("load data=%h en=%b", data_in, digit_en);
            @(negedge clk);
        end
        load = 1'b0;
        digit_en = 4'hF;
        do_load(16'h1234);

        // Asynchronous reset mid-scan while showing digit 2.
        wait_state("reset_wait", 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted at %0t", $time);
        check("rst_anode",       32'(anode),       32'hF);
        check("rst_digit_out",   32'(digit_out),   32'h0);
        check("rst_blank",       32'(blank),       32'h1);
        check("rst_sel",         32'(sel),         32'h0);
        check("rst_frame_done",  32'(frame_done),  32'h0);
        check("rst_anode8",      32'(anode8),      32'hFF);
        check("rst_sel8",        32'(sel8),        32'h0);
        check("rst_frame_done8", 32'(frame_done8), 32'h0);
        @(negedge clk);
        cyc(2);
        rst_n = 1'b1;
        do_load(16'h9876);
        cyc(30);

        check("queue_drained", 32'(exp_q.size() <= 1), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule
